// File: rtl/axi_lite_pkg.sv
// rtl/axi_lite_pkg.sv - shared types and helpers for the AXI-Lite register slave
package axi_lite_pkg;

  typedef enum logic [1:0] {
    OKAY   = 2'b00,
    SLVERR = 2'b10
  } resp_e;

  typedef enum logic {
    W_COLLECT = 1'b0,
    W_RESP    = 1'b1
  } wr_state_e;

  typedef enum logic {
    R_IDLE = 1'b0,
    R_RESP = 1'b1
  } rd_state_e;

  function automatic int strb_width(input int data_width);
    return data_width / 8;
  endfunction

endpackage

// File: rtl/axi_lite_reg_bank.sv
// rtl/axi_lite_reg_bank.sv - register storage with byte-strobe merge, read-only masking and write pulses
module axi_lite_reg_bank
  import axi_lite_pkg::*;
#(
  parameter int                    DATA_WIDTH = 32,
  parameter int                    NUM_REGS   = 16,
  parameter logic [NUM_REGS-1:0]   RO_MASK    = '0,
  parameter logic [DATA_WIDTH-1:0] RESET_VAL  = '0
) (
  input  logic                           clk,
  input  logic                           rst_n,
  input  logic                           wr_req_i,
  input  logic [7:0]                     wr_idx_i,
  input  logic [DATA_WIDTH-1:0]          wr_data_i,
  input  logic [DATA_WIDTH/8-1:0]        wr_strb_i,
  output logic                           wr_ro_o,
  output logic [NUM_REGS*DATA_WIDTH-1:0] regs_o,
  output logic [NUM_REGS-1:0]            wr_pulse_o
);

  localparam int STRB_W = strb_width(DATA_WIDTH);

  logic [DATA_WIDTH-1:0] regs_q [NUM_REGS];
  logic [DATA_WIDTH-1:0] regs_d [NUM_REGS];
  logic [NUM_REGS-1:0]   pulse_q, pulse_d;
  logic                  hit_ro;

  always_comb begin
    hit_ro = 1'b0;
    for (int i = 0; i < NUM_REGS; i++) begin
      if (wr_idx_i == 8'(i)) hit_ro = RO_MASK[i];
    end
  end

  assign wr_ro_o = hit_ro;

  // A write with no strobes still counts as a write and pulses.
  always_comb begin
    pulse_d = '0;
    for (int i = 0; i < NUM_REGS; i++) begin
      regs_d[i] = regs_q[i];
      if (wr_req_i && !RO_MASK[i] && (wr_idx_i == 8'(i))) begin
        pulse_d[i] = 1'b1;
        for (int b = 0; b < STRB_W; b++) begin
          if (wr_strb_i[b]) regs_d[i][b*8 +: 8] = wr_data_i[b*8 +: 8];
        end
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < NUM_REGS; i++) regs_q[i] <= RESET_VAL;
      pulse_q <= '0;
    end else begin
      for (int i = 0; i < NUM_REGS; i++) regs_q[i] <= regs_d[i];
      pulse_q <= pulse_d;
    end
  end

  for (genvar g = 0; g < NUM_REGS; g++) begin : g_flat
    assign regs_o[g*DATA_WIDTH +: DATA_WIDTH] = regs_q[g];
  end

  assign wr_pulse_o = pulse_q;

endmodule

// File: rtl/axi_lite_reg_slave.sv
// rtl/axi_lite_reg_slave.sv - AXI-Lite slave terminating the bus into a bank of memory-mapped registers
module axi_lite_reg_slave
  import axi_lite_pkg::*;
#(
  parameter int                    ADDR_WIDTH = 32,
  parameter int                    DATA_WIDTH = 32,
  parameter int                    ID_WIDTH   = 4,
  parameter int                    NUM_REGS   = 16,
  parameter logic [NUM_REGS-1:0]   RO_MASK    = '0,
  parameter logic [DATA_WIDTH-1:0] RESET_VAL  = '0
) (
  input  logic                           clk,
  input  logic                           rst,
  input  logic [ADDR_WIDTH-1:0]          araddr,
  input  logic [ID_WIDTH-1:0]            arid,
  input  logic                           arvalid,
  output logic                           arready,
  input  logic [ADDR_WIDTH-1:0]          awaddr,
  input  logic [ID_WIDTH-1:0]            awid,
  input  logic                           awvalid,
  output logic                           awready,
  input  logic [DATA_WIDTH-1:0]          wdata,
  input  logic [DATA_WIDTH/8-1:0]        wstrb,
  input  logic                           wvalid,
  output logic                           wready,
  output logic [DATA_WIDTH-1:0]          rdata,
  output logic [ID_WIDTH-1:0]            rid,
  output logic [1:0]                     rresp,
  output logic                           rvalid,
  input  logic                           rready,
  output logic [ID_WIDTH-1:0]            bid,
  output logic [1:0]                     bresp,
  output logic                           bvalid,
  input  logic                           bready,
  output logic [NUM_REGS*DATA_WIDTH-1:0] regs_o,
  output logic [NUM_REGS-1:0]            wr_pulse_o
);

  localparam int ADDR_LSB = $clog2(DATA_WIDTH / 8);

  // Address decode: bits above the 8-bit index field or an index past the bank are errors.
  logic [7:0] ar_idx, aw_idx;
  logic       ar_err, aw_err;
  logic       unused_addr_bits;

  assign ar_idx = araddr[ADDR_LSB +: 8];
  assign aw_idx = awaddr[ADDR_LSB +: 8];
  assign ar_err = ((araddr >> (ADDR_LSB + 8)) != '0) || ({1'b0, ar_idx} >= 9'(NUM_REGS));
  assign aw_err = ((awaddr >> (ADDR_LSB + 8)) != '0) || ({1'b0, aw_idx} >= 9'(NUM_REGS));
  assign unused_addr_bits = ^{araddr[ADDR_LSB-1:0], awaddr[ADDR_LSB-1:0]};

  wr_state_e               wr_state_q, wr_state_d;
  logic                    aw_held_q, aw_held_d;
  logic [7:0]              aw_idx_q, aw_idx_d;
  logic                    aw_err_q, aw_err_d;
  logic [ID_WIDTH-1:0]     awid_q, awid_d;
  logic                    w_held_q, w_held_d;
  logic [DATA_WIDTH-1:0]   wdata_q, wdata_d;
  logic [DATA_WIDTH/8-1:0] wstrb_q, wstrb_d;
  logic [ID_WIDTH-1:0]     bid_q, bid_d;
  resp_e                   bresp_q, bresp_d;
  logic                    commit, wr_ro;

  rd_state_e               rd_state_q, rd_state_d;
  logic [DATA_WIDTH-1:0]   rdata_q, rdata_d;
  logic [ID_WIDTH-1:0]     rid_q, rid_d;
  resp_e                   rresp_q, rresp_d;
  logic [DATA_WIDTH-1:0]   rd_word;

  assign commit = aw_held_q && w_held_q && (wr_state_q == W_COLLECT);

  axi_lite_reg_bank #(
    .DATA_WIDTH (DATA_WIDTH),
    .NUM_REGS   (NUM_REGS),
    .RO_MASK    (RO_MASK),
    .RESET_VAL  (RESET_VAL)
  ) u_bank (
    .clk        (clk),
    .rst_n      (rst),
    .wr_req_i   (commit && !aw_err_q),
    .wr_idx_i   (aw_idx_q),
    .wr_data_i  (wdata_q),
    .wr_strb_i  (wstrb_q),
    .wr_ro_o    (wr_ro),
    .regs_o     (regs_o),
    .wr_pulse_o (wr_pulse_o)
  );

  always_comb begin
    aw_held_d  = aw_held_q;
    aw_idx_d   = aw_idx_q;
    aw_err_d   = aw_err_q;
    awid_d     = awid_q;
    w_held_d   = w_held_q;
    wdata_d    = wdata_q;
    wstrb_d    = wstrb_q;
    bid_d      = bid_q;
    bresp_d    = bresp_q;
    wr_state_d = wr_state_q;
    awready    = !aw_held_q;
    wready     = !w_held_q;
    bvalid     = (wr_state_q == W_RESP);

    if (awvalid && !aw_held_q) begin
      aw_held_d = 1'b1;
      aw_idx_d  = aw_idx;
      aw_err_d  = aw_err;
      awid_d    = awid;
    end
    if (wvalid && !w_held_q) begin
      w_held_d = 1'b1;
      wdata_d  = wdata;
      wstrb_d  = wstrb;
    end

    case (wr_state_q)
      W_COLLECT: begin
        if (commit) begin
          aw_held_d  = 1'b0;
          w_held_d   = 1'b0;
          bid_d      = awid_q;
          bresp_d    = (aw_err_q || wr_ro) ? SLVERR : OKAY;
          wr_state_d = W_RESP;
        end
      end
      W_RESP: begin
        if (bready) wr_state_d = W_COLLECT;
      end
      default: wr_state_d = W_COLLECT;
    endcase
  end

  always_comb begin
    rd_word = '0;
    for (int i = 0; i < NUM_REGS; i++) begin
      if (ar_idx == 8'(i)) rd_word = regs_o[i*DATA_WIDTH +: DATA_WIDTH];
    end
  end

  // The read samples the register output before any same-edge commit lands.
  always_comb begin
    rd_state_d = rd_state_q;
    rdata_d    = rdata_q;
    rid_d      = rid_q;
    rresp_d    = rresp_q;
    arready    = (rd_state_q == R_IDLE);
    rvalid     = (rd_state_q == R_RESP);

    case (rd_state_q)
      R_IDLE: begin
        if (arvalid) begin
          rid_d      = arid;
          rdata_d    = ar_err ? '0 : rd_word;
          rresp_d    = ar_err ? SLVERR : OKAY;
          rd_state_d = R_RESP;
        end
      end
      R_RESP: begin
        if (rready) rd_state_d = R_IDLE;
      end
      default: rd_state_d = R_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wr_state_q <= W_COLLECT;
      aw_held_q  <= 1'b0;
      aw_idx_q   <= '0;
      aw_err_q   <= 1'b0;
      awid_q     <= '0;
      w_held_q   <= 1'b0;
      wdata_q    <= '0;
      wstrb_q    <= '0;
      bid_q      <= '0;
      bresp_q    <= OKAY;
      rd_state_q <= R_IDLE;
      rdata_q    <= '0;
      rid_q      <= '0;
      rresp_q    <= OKAY;
    end else begin
      wr_state_q <= wr_state_d;
      aw_held_q  <= aw_held_d;
      aw_idx_q   <= aw_idx_d;
      aw_err_q   <= aw_err_d;
      awid_q     <= awid_d;
      w_held_q   <= w_held_d;
      wdata_q    <= wdata_d;
      wstrb_q    <= wstrb_d;
      bid_q      <= bid_d;
      bresp_q    <= bresp_d;
      rd_state_q <= rd_state_d;
      rdata_q    <= rdata_d;
      rid_q      <= rid_d;
      rresp_q    <= rresp_d;
    end
  end

  assign bid   = bid_q;
  assign bresp = bresp_q;
  assign rdata = rdata_q;
  assign rid   = rid_q;
  assign rresp = rresp_q;

endmodule

// File: doc/axi_lite_reg_slave.md
Name: axi_lite_reg_slave

Overview:
Parametrised AXI-Lite slave terminating one AXI-Lite bus into a bank of NUM_REGS memory-mapped registers.
- Adds write IDs, byte strobes, response codes, read-only masking and independent AW/W acceptance.
- Exposes the register contents and per-register write pulses to core logic.
- Sits behind the bus fabric as the standard control/status endpoint for IP blocks.

Parameters:
ADDR_WIDTH, 32, byte-address width
DATA_WIDTH, 32, data width; 32 or 64 only
ID_WIDTH, 4, width of arid/rid/awid/bid
NUM_REGS, 16, register count, 1..256
RO_MASK, '0, NUM_REGS-bit mask; bit i set = register i read-only from bus
RESET_VAL, '0, reset value for every register

Ports:
clk  in  1  clock, all logic on posedge
rst  in  1  asynchronous, active-low reset
araddr  in  ADDR_WIDTH  read address
arid  in  ID_WIDTH  read ID
arvalid  in  1  read address valid
arready  out  1  read address ready
awaddr  in  ADDR_WIDTH  write address
awid  in  ID_WIDTH  write ID
awvalid  in  1  write address valid
awready  out  1  write address ready
wdata  in  DATA_WIDTH  write data
wstrb  in  DATA_WIDTH/8  byte strobes
wvalid  in  1  write data valid
wready  out  1  write data ready
rdata  out  DATA_WIDTH  read data
rid  out  ID_WIDTH  echoed arid
rresp  out  2  read response
rvalid  out  1  read valid
rready  in  1  read ready
bid  out  ID_WIDTH  echoed awid
bresp  out  2  write response
bvalid  out  1  write response valid
bready  in  1  write response ready
regs_o  out  NUM_REGS*DATA_WIDTH  flattened register contents; reg i at [i*DATA_WIDTH +: DATA_WIDTH]
wr_pulse_o  out  NUM_REGS  one-cycle pulse on a successful bus write to reg i

Behaviour:
Reset:
- rst low forces: all registers = RESET_VAL, both FSMs idle, held flags clear.
- All valids 0; rdata/rid/bid/rresp/bresp 0; wr_pulse_o 0.
- After release: arready = awready = wready = 1.
- Reset mid-transaction drops the transaction silently; no response is issued.

Address decode:
- ADDR_LSB = clog2(DATA_WIDTH/8); idx = addr[ADDR_LSB +: 8]; sub-word low bits are ignored.
- Decode error: any addr bit above ADDR_LSB+8 set, or idx >= NUM_REGS.

Write path:
- AW and W are captured independently into holding registers (aw_held, w_held).
- awready = !aw_held; wready = !w_held. Either may arrive first, or both in the same cycle.
- Commit fires when aw_held && w_held && !bvalid, on the cycle after the later of AW/W is accepted.
- Commit actions: clear both held flags, set bvalid, bid = held awid.
- Decode ok and RO_MASK[idx]=0: for each byte b with wstrb[b]=1, replace byte b of reg idx. bresp = OKAY (2'b00). wr_pulse_o[idx] = 1 for that one cycle, even when wstrb = 0.
- Decode error or RO register: no update, no pulse, bresp = SLVERR (2'b10).
- bvalid holds, with bid/bresp stable, until bready. While bvalid && !bready, held AW/W wait and are not committed.
- Write FSM states: W_COLLECT -> W_RESP -> (bready) -> W_COLLECT.

Read path:
- Read FSM states: R_IDLE (arready=1) -> R_RESP on arvalid (arready=0, rvalid=1 next cycle) -> R_IDLE on rready.
- Response: rid = arid. rdata = reg idx sampled at the AR accept edge, with rresp OKAY; decode error gives rdata = 0, rresp SLVERR. RO registers read normally.
- Throughput: one read per 2 cycles when rready is held high.
- rdata/rid/rresp stay stable while rvalid && !rready.

Simultaneous events:
- AR acceptance and a write commit to the same register on the same edge: the read returns the pre-write value.
- Read and write channels are fully independent; neither stalls the other.

Decomposition:
- Package axi_lite_pkg: resp_e (OKAY=2'b00, SLVERR=2'b10), wr_state_e, rd_state_e, a DATA_WIDTH-to-strobe-width helper function.
- Sub-module axi_lite_reg_bank: register storage, strobe merge, RO masking, wr_pulse generation.
- The top module keeps both FSMs and the address decode.

Test Plan:
- After reset, AW (0x08, id 3) and W (0xDEADBEEF, strb 0xF) in the same cycle -> bvalid 1 cycle later; bid=3, bresp=OKAY, wr_pulse_o[2]=1; read 0x08 returns 0xDEADBEEF, rresp OKAY.
- W sent 3 cycles before AW to 0x04 -> wready drops after W acceptance; commit on the cycle after AW accept; reg1 updated.
- Strobed write wstrb=0x3, wdata 0x12345678 over reg0=0xAAAAAAAA -> reg0 = 0xAAAA5678.
- Write to 0x40 (idx 16, NUM_REGS=16), and write to an RO_MASK register -> both give bresp SLVERR, no pulse, contents unchanged; read 0x40 -> rdata 0, rresp SLVERR.
- Hold bready low 5 cycles with a second AW+W queued -> second commit waits, bid/bresp stable; second response follows bready.
- Assert rst low while rvalid=1 -> rvalid, bvalid go 0 immediately; regs_o = RESET_VAL; no response after release.
